// File: rtl/alu_fu.sv
// alu_fu: pipelined integer ALU functional unit with an OUT_DEPTH-entry result FIFO feeding the CDB.
// Latency: 1 cycle from issue acceptance to cdb_valid when the FIFO was empty.
// Backpressure: issue_ready drops when the FIFO is full; the head holds until cdb_gnt.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   flush             discards all buffered results and any issue in the same cycle
//   issue_*           valid/ready instruction input: raw RV32 word, operands, ROB tag
//   cdb_valid/cdb_gnt request/grant broadcast; cdb_tag and cdb_result show the FIFO head
//   occupancy         registered FIFO entry count
//
// Optional feature macro: ALU_ZBA_EN adds sh1add/sh2add/sh3add on op-reg with funct7=0010000.
// When it is undefined, those encodings are unsupported and broadcast a result of 0.

module alu_fu #(
  parameter int ROB_DEPTH = 4,
  parameter int XLEN      = 32,
  parameter int OUT_DEPTH = 2,
  localparam int TW = $clog2(ROB_DEPTH),
  localparam int CW = $clog2(OUT_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_instr,
  input  logic [XLEN-1:0] issue_rs1_v,
  input  logic [XLEN-1:0] issue_rs2_v,
  input  logic [TW-1:0]   issue_rob_tag,
  output logic            cdb_valid,
  input  logic            cdb_gnt,
  output logic [TW-1:0]   cdb_tag,
  output logic [XLEN-1:0] cdb_result,
  output logic [CW-1:0]   occupancy
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int SW = $clog2(XLEN);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_ZBA_EN
  localparam logic [6:0] F7_ZBA  = 7'b0010000;
`endif

  // ---------------------------------------------------------------------------
  // Decode and execute
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      imm_hi;
  logic [SW-1:0]   shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] alu_res;
  logic            unused_instr_bits;

  assign opcode = issue_instr[6:0];
  assign funct3 = issue_instr[14:12];
  assign funct7 = issue_instr[31:25];
  // On RV64 the shift-immediate uses instr[25] as shamt[5]; only the upper six bits qualify it.
  assign imm_hi = (XLEN == 64) ? {issue_instr[31:26], 1'b0} : issue_instr[31:25];
  assign shamt  = issue_rs2_v[SW-1:0];
  assign lt_s   = $signed(issue_rs1_v) < $signed(issue_rs2_v);
  assign lt_u   = issue_rs1_v < issue_rs2_v;

  // Register-number and rd fields are resolved by rename; the unit only needs the opcode fields.
  assign unused_instr_bits = ^{issue_instr[24:15], issue_instr[11:7]};

  always_comb begin
    alu_res = '0;
    unique case (opcode)
      OP_LUI:   alu_res = issue_rs2_v;
      OP_AUIPC: alu_res = issue_rs1_v + issue_rs2_v;
      OP_IMM: begin
        unique case (funct3)
          3'b000: alu_res = issue_rs1_v + issue_rs2_v;
          3'b001: if (imm_hi == F7_BASE) alu_res = issue_rs1_v << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100: alu_res = issue_rs1_v ^ issue_rs2_v;
          3'b101: begin
            if (imm_hi == F7_BASE)     alu_res = issue_rs1_v >> shamt;
            else if (imm_hi == F7_ALT) alu_res = $unsigned($signed(issue_rs1_v) >>> shamt);
          end
          3'b110: alu_res = issue_rs1_v | issue_rs2_v;
          default: alu_res = issue_rs1_v & issue_rs2_v;
        endcase
      end
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000: alu_res = issue_rs1_v + issue_rs2_v;
            3'b001: alu_res = issue_rs1_v << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: alu_res = issue_rs1_v ^ issue_rs2_v;
            3'b101: alu_res = issue_rs1_v >> shamt;
            3'b110: alu_res = issue_rs1_v | issue_rs2_v;
            default: alu_res = issue_rs1_v & issue_rs2_v;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      alu_res = issue_rs1_v - issue_rs2_v;
          else if (funct3 == 3'b101) alu_res = $unsigned($signed(issue_rs1_v) >>> shamt);
        end
`ifdef ALU_ZBA_EN
        else if (funct7 == F7_ZBA) begin
          if (funct3 == 3'b010)      alu_res = (issue_rs1_v << 1) + issue_rs2_v;
          else if (funct3 == 3'b100) alu_res = (issue_rs1_v << 2) + issue_rs2_v;
          else if (funct3 == 3'b110) alu_res = (issue_rs1_v << 3) + issue_rs2_v;
        end
`endif
      end
      // Anything else still completes with 0 so the ROB entry retires.
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [TW-1:0]   tag_mem [OUT_DEPTH];
  logic [XLEN-1:0] res_mem [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            not_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty   = (count != '0);
  assign issue_ready = (count < CW'(OUT_DEPTH));
  assign push        = issue_valid && issue_ready && !flush;
  // cdb_valid already carries !flush, so a grant during flush cannot pop.
  assign pop         = cdb_valid && cdb_gnt;

  assign cdb_valid   = not_empty && !flush;
  assign cdb_tag     = not_empty ? tag_mem[rd_ptr] : '0;
  assign cdb_result  = not_empty ? res_mem[rd_ptr] : '0;
  assign occupancy   = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to 0 whenever count is 0.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      tag_mem[wr_ptr] <= issue_rob_tag;
      res_mem[wr_ptr] <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_fu.sv
// tb_alu_fu: self-checking bench for alu_fu (default parameters, XLEN=32, OUT_DEPTH=2).
// Directed vector table, hand-written back-pressure and flush sequences, then random traffic.
// A queue-based reference model predicts the FIFO head, occupancy and readiness every cycle.

module tb_alu_fu;

  localparam int ROB_DEPTH = 4;
  localparam int XLEN      = 32;
  localparam int OUT_DEPTH = 2;
  localparam int TW        = 2;
  localparam int CW        = 2;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instr;
  logic [XLEN-1:0] issue_rs1_v;
  logic [XLEN-1:0] issue_rs2_v;
  logic [TW-1:0]   issue_rob_tag;
  logic            cdb_valid;
  logic            cdb_gnt;
  logic [TW-1:0]   cdb_tag;
  logic [XLEN-1:0] cdb_result;
  logic [CW-1:0]   occupancy;

  alu_fu #(.ROB_DEPTH(ROB_DEPTH), .XLEN(XLEN), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_rs1_v(issue_rs1_v), .issue_rs2_v(issue_rs2_v), .issue_rob_tag(issue_rob_tag),
    .cdb_valid(cdb_valid), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sh;
    longint     sa, sb, ua;
    bit         is_reg, alt;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    if (op == 7'h37) return b;
    if (op == 7'h17) return a + b;
    if (op != 7'h13 && op != 7'h33) return 32'd0;
    is_reg = (op == 7'h33);
    alt    = (f7 == 7'h20);
    if (is_reg && f7 == 7'h10) begin
`ifdef ALU_ZBA_EN
      if (f3 == 3'd2) return a * 2 + b;
      if (f3 == 3'd4) return a * 4 + b;
      if (f3 == 3'd6) return a * 8 + b;
`endif
      return 32'd0;
    end
    if (is_reg && f7 != 7'h00 && !(alt && (f3 == 3'd0 || f3 == 3'd5))) return 32'd0;
    if (!is_reg && f3 == 3'd1 && f7 != 7'h00) return 32'd0;
    if (!is_reg && f3 == 3'd5 && f7 != 7'h00 && !alt) return 32'd0;
    case (f3)
      3'd0: return (is_reg && alt) ? a - b : a + b;
      3'd1: return 32'(ua * (longint'(1) << sh));
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (ua < longint'(b)) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> sh) : 32'(ua / (longint'(1) << sh));
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   res;
  } ent_t;

  ent_t mq[$];
  int   popped[$];
  bit   last_acc;
  logic            seen_vld, seen_rdy;
  logic [TW-1:0]   seen_tag;
  logic [31:0]     seen_res;
  logic [CW-1:0]   seen_occ;

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit   do_pop, do_acc;
    ent_t e;
    @(negedge clk);
    seen_vld = cdb_valid;
    seen_rdy = issue_ready;
    seen_tag = cdb_tag;
    seen_res = cdb_result;
    seen_occ = occupancy;
    if (!rst_n) begin
      check("rst_cdb_valid", cdb_valid, 0);
      check("rst_occupancy", occupancy, 0);
    end else begin
      check("issue_ready", issue_ready, (mq.size() < OUT_DEPTH));
      check("occupancy", occupancy, mq.size());
      check("cdb_valid", cdb_valid, (mq.size() != 0 && !flush));
      if (mq.size() != 0 && !flush) begin
        check("cdb_tag", cdb_tag, mq[0].tag);
        check("cdb_result", cdb_result, mq[0].res);
      end else if (mq.size() == 0) begin
        check("idle_tag", cdb_tag, 0);
        check("idle_result", cdb_result, 0);
      end
    end
    do_pop = rst_n && !flush && mq.size() != 0 && cdb_gnt;
    do_acc = rst_n && !flush && issue_valid && mq.size() < OUT_DEPTH;
    e.tag  = issue_rob_tag;
    e.res  = ref_alu(issue_instr, issue_rs1_v, issue_rs2_v);
    @(posedge clk);
    if (!rst_n || flush) mq.delete();
    else begin
      if (do_pop) begin
        popped.push_back(int'(mq[0].tag));
        void'(mq.pop_front());
      end
      if (do_acc) mq.push_back(e);
    end
    last_acc = do_acc;
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
    issue_valid   = 1'b1;
    issue_instr   = ins;
    issue_rs1_v   = a;
    issue_rs2_v   = b;
    issue_rob_tag = tag;
  endtask

  task automatic drain();
    issue_valid = 1'b0;
    flush       = 1'b0;
    cdb_gnt     = 1'b1;
    for (int k = 0; k < 2 * OUT_DEPTH + 2; k++) cycle();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 9);
    if (k == 1) ins[6:0] = 7'h37;
    else if (k == 2) ins[6:0] = 7'h17;
    else if (k >= 3 && k <= 5) begin
      ins[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else if (k >= 6) begin
      ins[6:0] = 7'h33;
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h10;
        default: ins[31:25] = 7'($urandom);
      endcase
    end
    return ins;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [TW-1:0] tag;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{"add_ovf",  enc(7'h33, 3'd0, 7'h00), 32'h7FFF_FFFF, 32'h1,          2'd2, 32'h8000_0000};
    vt[1]  = '{"sra",      enc(7'h33, 3'd5, 7'h20), 32'hF000_0000, 32'h24,         2'd1, 32'hFF00_0000};
    vt[2]  = '{"slt",      enc(7'h33, 3'd2, 7'h00), 32'hFFFF_FFFF, 32'h1,          2'd3, 32'h1};
    vt[3]  = '{"sltu",     enc(7'h33, 3'd3, 7'h00), 32'hFFFF_FFFF, 32'h1,          2'd0, 32'h0};
    vt[4]  = '{"sub",      enc(7'h33, 3'd0, 7'h20), 32'd5,         32'd7,          2'd1, 32'hFFFF_FFFE};
    vt[5]  = '{"sll",      enc(7'h33, 3'd1, 7'h00), 32'h1,         32'h21,         2'd2, 32'h2};
    vt[6]  = '{"srl",      enc(7'h33, 3'd5, 7'h00), 32'h8000_0000, 32'h4,          2'd3, 32'h0800_0000};
    vt[7]  = '{"xori",     enc(7'h13, 3'd4, 7'h55), 32'hFF00_FF00, 32'h0F0F_0F0F,  2'd0, 32'hF00F_F00F};
    vt[8]  = '{"ori",      enc(7'h13, 3'd6, 7'h00), 32'hF0,        32'h0F,         2'd1, 32'hFF};
    vt[9]  = '{"andi",     enc(7'h13, 3'd7, 7'h00), 32'hF0F0,      32'hFF00,       2'd2, 32'hF000};
    vt[10] = '{"lui",      enc(7'h37, 3'd0, 7'h00), 32'd123,       32'h1234_5000,  2'd3, 32'h1234_5000};
    vt[11] = '{"auipc",    enc(7'h17, 3'd0, 7'h00), 32'h1000,      32'h2000,       2'd0, 32'h3000};
    vt[12] = '{"srai_bad", enc(7'h13, 3'd5, 7'h7F), 32'h8000_0000, 32'h1,          2'd1, 32'h0};
`ifdef ALU_ZBA_EN
    vt[13] = '{"sh2add",   enc(7'h33, 3'd4, 7'h10), 32'd3,         32'd5,          2'd2, 32'd17};
`else
    vt[13] = '{"sh2add",   enc(7'h33, 3'd4, 7'h10), 32'd3,         32'd5,          2'd2, 32'd0};
`endif

    // Reset held for two cycles with an issue pending.
    rst_n = 1'b0; flush = 1'b0; cdb_gnt = 1'b0;
    drive(enc(7'h33, 3'd0, 7'h00), 32'd1, 32'd2, 2'd1);
    cycle();
    cycle();
    rst_n = 1'b1;
    issue_valid = 1'b0;
    cycle();
    check("rst_ready", seen_rdy, 1);

    // Directed table: one issue, then observe the broadcast with grant held.
    for (int i = 0; i < NV; i++) begin
      cdb_gnt = 1'b1;
      drive(vt[i].instr, vt[i].a, vt[i].b, vt[i].tag);
      cycle();
      issue_valid = 1'b0;
      cycle();
      check({vt[i].name, "_vld"}, seen_vld, 1);
      check({vt[i].name, "_res"}, seen_res, vt[i].exp);
      check({vt[i].name, "_tag"}, seen_tag, vt[i].tag);
    end
    cycle();
    check("post_table_occ", seen_occ, 0);

    // Back-pressure: three back-to-back issues with no grant.
    drain();
    cdb_gnt = 1'b0;
    drive(enc(7'h33, 3'd0, 7'h00), 32'd10, 32'd0, 2'd0); cycle();
    drive(enc(7'h33, 3'd0, 7'h00), 32'd11, 32'd0, 2'd1); cycle();
    drive(enc(7'h33, 3'd0, 7'h00), 32'd12, 32'd0, 2'd2); cycle();
    check("bp_ready", seen_rdy, 0);
    check("bp_occ", seen_occ, 2);
    check("bp_head_tag", seen_tag, 0);
    cycle();
    check("bp_hold_tag", seen_tag, 0);
    check("bp_hold_res", seen_res, 32'd10);
    check("bp_still_blocked", last_acc, 0);
    cdb_gnt = 1'b1;
    popped.delete();
    for (int k = 0; k < 10 && popped.size() < 3; k++) begin
      cycle();
      if (last_acc) issue_valid = 1'b0;
    end
    check("bp_pop_count", popped.size(), 3);
    for (int k = 0; k < 3; k++) check("bp_order", (k < popped.size()) ? popped[k] : -1, k);

    // Flush with two entries buffered and a same-cycle issue.
    drain();
    cdb_gnt = 1'b0;
    drive(enc(7'h33, 3'd0, 7'h00), 32'd1, 32'd1, 2'd1); cycle();
    drive(enc(7'h33, 3'd0, 7'h00), 32'd3, 32'd3, 2'd3); cycle();
    drive(enc(7'h33, 3'd0, 7'h00), 32'd2, 32'd2, 2'd2);
    flush = 1'b1;
    cdb_gnt = 1'b1;
    cycle();
    check("flush_vld", seen_vld, 0);
    check("flush_no_accept", last_acc, 0);
    flush = 1'b0;
    issue_valid = 1'b0;
    popped.delete();
    cycle();
    check("flush_occ", seen_occ, 0);
    check("flush_ready", seen_rdy, 1);
    check("flush_vld_next", seen_vld, 0);
    for (int k = 0; k < 3; k++) cycle();
    check("flush_no_bcast", popped.size(), 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      drive(rand_instr(), rand_operand(), rand_operand(), 2'($urandom));
      issue_valid = ($urandom_range(0, 3) != 0);
      cdb_gnt     = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
